// File: rtl/ahb_ui_sequencer_if.sv
// Command, write-data and master-UI signal bundle for ahb_ui_sequencer.
// The slave modport is the sequencer's view; the master modport drives commands and strobes.
interface ahb_ui_sequencer_if #(
  parameter int DATA_WDT = 32,
  parameter int BEAT_WDT = 32
);
  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [31:0]         i_cmd_addr;
  logic [2:0]          i_cmd_size;
  logic                i_cmd_wr;
  logic [BEAT_WDT-1:0] i_cmd_len;
  logic                i_wdata_valid;
  logic                o_wdata_ready;
  logic [DATA_WDT-1:0] i_wdata;
  logic                i_next;
  logic [31:0]         o_ui_addr;
  logic [2:0]          o_ui_size;
  logic                o_ui_wr;
  logic                o_ui_rd;
  logic [BEAT_WDT-1:0] o_ui_min_len;
  logic                o_ui_cont;
  logic [DATA_WDT-1:0] o_ui_data;
  logic                o_ui_dav;
  logic                o_busy;
  logic                o_cmd_done;

  modport slave (
    input  i_cmd_valid, i_cmd_addr, i_cmd_size, i_cmd_wr, i_cmd_len,
    input  i_wdata_valid, i_wdata, i_next,
    output o_cmd_ready, o_wdata_ready,
    output o_ui_addr, o_ui_size, o_ui_wr, o_ui_rd, o_ui_min_len, o_ui_cont,
    output o_ui_data, o_ui_dav, o_busy, o_cmd_done
  );

  modport master (
    output i_cmd_valid, i_cmd_addr, i_cmd_size, i_cmd_wr, i_cmd_len,
    output i_wdata_valid, i_wdata, i_next,
    input  o_cmd_ready, o_wdata_ready,
    input  o_ui_addr, o_ui_size, o_ui_wr, o_ui_rd, o_ui_min_len, o_ui_cont,
    input  o_ui_data, o_ui_dav, o_busy, o_cmd_done
  );
endinterface

// File: rtl/ahb_ui_sequencer.sv
// Burst command sequencer in front of the AHB master UI, with a FWFT write-data FIFO.
// All outputs decode from registered state, so i_next never reaches an output combinationally.
module ahb_ui_sequencer #(
  parameter int DATA_WDT   = 32,
  parameter int BEAT_WDT   = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic i_hclk,
  input  logic i_hreset,
  ahb_ui_sequencer_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BURST, S_END} state_t;

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_addr;
  logic [2:0]          r_size;
  logic                r_wr;
  logic [BEAT_WDT-1:0] r_len, r_rem;
  logic                r_done;

  logic [DATA_WDT-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [PW:0]         r_cnt;

  logic w_empty, w_full, w_active, w_rd, w_dav, w_take;
  logic w_accept, w_push, w_pop, w_last, w_done_set;

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == (PW+1)'(FIFO_DEPTH));
  assign w_active   = (r_state == S_START) || (r_state == S_BURST);
  assign w_rd       = w_active && !r_wr;
  assign w_dav      = w_active && r_wr && !w_empty;
  assign w_take     = bus.i_next && (w_rd || w_dav);
  assign w_accept   = bus.i_cmd_valid && (r_state == S_IDLE);
  assign w_push     = bus.i_wdata_valid && !w_full;
  assign w_pop      = w_take && r_wr;
  // r_rem counts beats still to present, including the one on the UI now
  assign w_last     = (r_rem == BEAT_WDT'(1));
  assign w_done_set = (w_accept && (bus.i_cmd_len == '0)) ||
                      ((r_state == S_END) && bus.i_next);

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:          if (w_accept && (bus.i_cmd_len != '0)) w_state_nxt = S_START;
      S_START, S_BURST: if (w_take) w_state_nxt = w_last ? S_END : S_BURST;
      S_END:           if (bus.i_next) w_state_nxt = S_IDLE;
      default:         w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_addr <= '0;
      r_size <= '0;
      r_wr   <= 1'b0;
      r_len  <= '0;
      r_rem  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_accept) begin
        r_addr <= bus.i_cmd_addr;
        r_size <= bus.i_cmd_size;
        r_wr   <= bus.i_cmd_wr;
        r_len  <= bus.i_cmd_len;
        r_rem  <= bus.i_cmd_len;
      end else if (w_take) begin
        r_rem  <= r_rem - BEAT_WDT'(1);
      end
    end
  end

  // Storage is not reset; the head is masked while empty so stale words never show
  always_ff @(posedge i_hclk) begin
    if (w_push) r_mem[r_wptr] <= bus.i_wdata;
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.o_cmd_ready   = (r_state == S_IDLE);
  assign bus.o_wdata_ready = !w_full;
  assign bus.o_ui_addr     = r_addr;
  assign bus.o_ui_size     = r_size;
  assign bus.o_ui_min_len  = r_len;
  assign bus.o_ui_wr       = w_active && r_wr;
  assign bus.o_ui_rd       = w_rd;
  assign bus.o_ui_cont     = (r_state == S_BURST);
  assign bus.o_ui_dav      = w_dav;
  assign bus.o_ui_data     = w_empty ? '0 : r_mem[r_rptr];
  assign bus.o_busy        = (r_state != S_IDLE);
  assign bus.o_cmd_done    = r_done;
endmodule

// File: tb/tb_ahb_ui_sequencer.sv
// Bench for ahb_ui_sequencer: directed scenarios plus random traffic, all checked
// against a beat-level model (command in flight, beats taken, queue of pushed words).
module tb_ahb_ui_sequencer;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_ui_sequencer_if #(.DATA_WDT(32), .BEAT_WDT(32)) u_if ();

  ahb_ui_sequencer #(.DATA_WDT(32), .BEAT_WDT(32), .FIFO_DEPTH(FD)) u_dut (
    .i_hclk   (clk),
    .i_hreset (rst),
    .bus      (u_if)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one command in flight, FIFO as a queue of words in push order
  logic [31:0] wq[$];
  bit          m_active, m_endw, m_done_pend;
  logic [31:0] m_addr, m_len;
  logic [2:0]  m_size;
  bit          m_wr;
  int          m_beats;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl", {u_if.o_busy, u_if.o_cmd_ready, u_if.o_wdata_ready, u_if.o_ui_rd,
                      u_if.o_ui_wr, u_if.o_ui_cont, u_if.o_ui_dav, u_if.o_cmd_done}, 64'h60);
      chk("rst_bus", {u_if.o_ui_addr, u_if.o_ui_size} | u_if.o_ui_min_len | u_if.o_ui_data, 0);
      wq.delete();
      m_active = 0; m_endw = 0; m_done_pend = 0;
    end else begin
      bit idle, take, push;
      chk("done", u_if.o_cmd_done, m_done_pend);
      m_done_pend = 0;
      chk("wrdy", u_if.o_wdata_ready, wq.size() < FD);
      idle = !m_active && !m_endw;
      if (m_active) begin
        chk("busy", u_if.o_busy, 1);
        chk("cmdrdy", u_if.o_cmd_ready, 0);
        chk("rd", u_if.o_ui_rd, !m_wr);
        chk("wr", u_if.o_ui_wr, m_wr);
        chk("cont", u_if.o_ui_cont, m_beats != 0);
        chk("addr", u_if.o_ui_addr, m_addr);
        chk("size", u_if.o_ui_size, m_size);
        chk("minlen", u_if.o_ui_min_len, m_len);
        chk("dav", u_if.o_ui_dav, m_wr && wq.size() > 0);
        if (m_wr && wq.size() > 0) chk("data", u_if.o_ui_data, wq[0]);
      end else begin
        chk("busy", u_if.o_busy, m_endw);
        chk("cmdrdy", u_if.o_cmd_ready, idle);
        chk("ui_quiet", {u_if.o_ui_rd, u_if.o_ui_wr, u_if.o_ui_cont, u_if.o_ui_dav}, 0);
      end
      // events that the coming edge will commit
      take = m_active && u_if.i_next && (!m_wr || wq.size() > 0);
      push = u_if.i_wdata_valid && (wq.size() < FD);
      if (m_endw && u_if.i_next) begin
        m_endw = 0;
        m_done_pend = 1;
      end
      if (take) begin
        if (m_wr) void'(wq.pop_front());
        m_beats++;
        if (m_beats == m_len) begin
          m_active = 0;
          m_endw = 1;
        end
      end
      if (push) wq.push_back(u_if.i_wdata);
      if (idle && u_if.i_cmd_valid) begin
        m_addr = u_if.i_cmd_addr; m_size = u_if.i_cmd_size;
        m_wr = u_if.i_cmd_wr; m_len = u_if.i_cmd_len; m_beats = 0;
        if (u_if.i_cmd_len == 0) m_done_pend = 1;
        else m_active = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [2:0] s, input bit w, input int len);
    bit acc = 0;
    u_if.i_cmd_valid = 1; u_if.i_cmd_addr = a; u_if.i_cmd_size = s;
    u_if.i_cmd_wr = w; u_if.i_cmd_len = len;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = u_if.o_cmd_ready;
      step();
    end
    u_if.i_cmd_valid = 0;
    if (!acc) chk("cmd_timeout", 0, 1);
  endtask

  task automatic push_word(input logic [31:0] d);
    u_if.i_wdata_valid = 1; u_if.i_wdata = d;
    step();
    u_if.i_wdata_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = !u_if.o_busy;
    end
    chk(tag, ok, 1);
    step(); step();
  endtask

  initial begin
    u_if.i_cmd_valid = 0; u_if.i_cmd_addr = 0; u_if.i_cmd_size = 0; u_if.i_cmd_wr = 0;
    u_if.i_cmd_len = 0; u_if.i_wdata_valid = 0; u_if.i_wdata = 0; u_if.i_next = 0;
    repeat (3) step();
    rst = 0;
    step();

    // read burst, next held high: best-case timing
    u_if.i_next = 1;
    send_cmd(32'h100, 3'd2, 0, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rd4_cont", u_if.o_ui_cont, i != 0);
      step();
    end
    @(negedge clk); chk("rd4_end", {u_if.o_busy, u_if.o_ui_rd}, 2'b10);
    step();
    @(negedge clk); chk("rd4_done", {u_if.o_cmd_done, u_if.o_busy}, 2'b10);
    step();

    // write burst with data preloaded
    push_word(32'hA); push_word(32'hB); push_word(32'hC);
    send_cmd(32'h200, 3'd2, 1, 3);
    wait_idle("wr3_idle");
    chk("wr3_empty_wrdy", u_if.o_wdata_ready, 1);

    // write burst starved mid-way
    push_word(32'h1);
    send_cmd(32'h300, 3'd2, 1, 4);
    for (int i = 2; i <= 4; i++) begin
      step(); step();
      push_word(i);
    end
    wait_idle("wr4_idle");

    // write burst with empty FIFO parks in the first beat
    send_cmd(32'h400, 3'd1, 1, 2);
    repeat (4) step();
    @(negedge clk);
    chk("park", {u_if.o_ui_wr, u_if.o_ui_cont, u_if.o_ui_dav, u_if.o_busy}, 4'b1001);
    step();
    push_word(32'h55); push_word(32'h66);
    wait_idle("park_idle");

    // read with next stalls
    u_if.i_next = 0;
    send_cmd(32'h500, 3'd0, 0, 3);
    begin
      bit pat[7] = '{1, 0, 0, 1, 1, 1, 1};
      for (int i = 0; i < 7; i++) begin
        u_if.i_next = pat[i];
        step();
        if (i == 1 || i == 2) begin
          @(negedge clk); chk("stall_cont", {u_if.o_ui_cont, u_if.o_ui_rd}, 2'b11);
        end
      end
    end
    u_if.i_next = 1;
    wait_idle("stall_idle");

    // zero-length command, then fill the FIFO, then reset mid-burst
    send_cmd(32'h600, 3'd2, 1, 0);
    @(negedge clk); chk("len0", {u_if.o_cmd_done, u_if.o_busy}, 2'b10);
    step();
    u_if.i_next = 0;
    for (int i = 0; i < FD; i++) push_word(32'hF0 + i);
    @(negedge clk); chk("full", u_if.o_wdata_ready, 0);
    step();
    u_if.i_next = 1;
    send_cmd(32'h700, 3'd2, 1, 5);
    step();
    rst = 1;
    repeat (3) step();
    rst = 0;
    step();
    u_if.i_next = 0;
    send_cmd(32'h800, 3'd2, 1, 1);
    @(negedge clk); chk("post_rst_dav", {u_if.o_ui_dav, u_if.o_ui_wr}, 2'b01);
    step();
    u_if.i_next = 1;
    push_word(32'h99);
    wait_idle("post_rst_idle");

    // random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit acc;
      @(negedge clk);
      acc = u_if.i_cmd_valid && u_if.o_cmd_ready;
      step();
      if (acc || !u_if.i_cmd_valid) begin
        u_if.i_cmd_valid = ($urandom_range(0, 3) == 0);
        u_if.i_cmd_addr  = $urandom;
        u_if.i_cmd_size  = 3'($urandom_range(0, 2));
        u_if.i_cmd_wr    = 1'($urandom);
        u_if.i_cmd_len   = $urandom_range(0, 6);
      end
      u_if.i_next        = ($urandom_range(0, 3) != 0);
      u_if.i_wdata_valid = ($urandom_range(0, 2) == 0);
      u_if.i_wdata       = $urandom;
    end
    u_if.i_cmd_valid = 0;
    u_if.i_next = 1;
    u_if.i_wdata_valid = 1;
    wait_idle("rand_drain");
    u_if.i_wdata_valid = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
